// File: rtl/sdf_bitrev_reorder_if.sv
// Purpose: handshake/data bundle between the last SDF stage and the
//          bit-reversal reorder buffer (input stream) and its consumer
//          (natural-order output stream).
// Signals:
//   enable_in             sample valid on in_re/in_im (bit-reversed order)
//   in_re, in_im          input sample, WIDTH-bit two's complement
//   enable_out            out_re/out_im/out_index valid
//   out_re, out_im        output sample, natural order
//   out_index             frequency bin of the current output
//   out_last              high with bin N-1 of each frame
// Modports: master = sample producer / result consumer, slave = reorder buffer.
interface sdf_bitrev_reorder_if #(
  parameter int WIDTH = 8,
  parameter int LOG2N = 4
);
  logic             enable_in;
  logic [WIDTH-1:0] in_re;
  logic [WIDTH-1:0] in_im;
  logic             enable_out;
  logic [WIDTH-1:0] out_re;
  logic [WIDTH-1:0] out_im;
  logic [LOG2N-1:0] out_index;
  logic             out_last;

  modport master (
    output enable_in, in_re, in_im,
    input  enable_out, out_re, out_im, out_index, out_last
  );

  modport slave (
    input  enable_in, in_re, in_im,
    output enable_out, out_re, out_im, out_index, out_last
  );
endinterface

// File: rtl/sdf_bitrev_reorder.sv
// Purpose: output reorder buffer for the radix-2^2 SDF FFT. Collects an
//          N-point frame arriving in bit-reversed order and streams it out
//          in natural order. Two banks of N complex words let one frame be
//          written while the previous one is read, so back-to-back frames
//          run at one sample per cycle with no bubble.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     sdf_bitrev_reorder_if.slave (input stream in, reordered stream out)
//
// state  | meaning
// IDLE   | no completed frame pending, outputs hold, enable_out low
// STREAM | emitting bins 0..N-1 of rd_bank, one per cycle
module sdf_bitrev_reorder #(
  parameter int WIDTH = 8,
  parameter int N     = 16,
  parameter int LOG2N = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sdf_bitrev_reorder_if.slave   bus
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = k[LOG2N-1-i];
    return r;
  endfunction

  // Storage: address = {bank, index}; contents intentionally not reset.
  logic [2*WIDTH-1:0] r_mem [0:2*N-1];

  logic [LOG2N-1:0]   r_wr_cnt;
  logic               r_wr_bank;
  logic [LOG2N-1:0]   r_rd_cnt;
  logic               r_rd_bank;
  state_t             r_state;

  logic               r_enable_out;
  logic [WIDTH-1:0]   r_out_re;
  logic [WIDTH-1:0]   r_out_im;
  logic [LOG2N-1:0]   r_out_index;
  logic               r_out_last;

  logic               w_frame_done;
  logic [LOG2N:0]     w_wr_addr;
  logic [LOG2N:0]     w_rd_addr;
  logic [2*WIDTH-1:0] w_rd_word;

  // Frame completes on the edge that writes the last sample.
  assign w_frame_done = bus.enable_in && (r_wr_cnt == LAST);
  assign w_wr_addr    = {r_wr_bank, bitrev(r_wr_cnt)};
  assign w_rd_addr    = {r_rd_bank, r_rd_cnt};
  assign w_rd_word    = r_mem[w_rd_addr];

  always_ff @(posedge clk) begin
    if (bus.enable_in) r_mem[w_wr_addr] <= {bus.in_re, bus.in_im};
  end

  // Write side: counter holds through input gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else if (bus.enable_in) begin
      r_wr_cnt <= r_wr_cnt + 1'b1;
      if (r_wr_cnt == LAST) r_wr_bank <= ~r_wr_bank;
    end
  end

  // Read FSM with registered outputs. The bank just completed is r_wr_bank
  // in the frame_done cycle (it toggles on the same edge), so capture it here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rd_cnt     <= '0;
      r_rd_bank    <= 1'b0;
      r_enable_out <= 1'b0;
      r_out_re     <= '0;
      r_out_im     <= '0;
      r_out_index  <= '0;
      r_out_last   <= 1'b0;
    end else begin
      r_enable_out <= 1'b0;
      r_out_last   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_frame_done) begin
            r_state   <= STREAM;
            r_rd_bank <= r_wr_bank;
            r_rd_cnt  <= '0;
          end
        end
        STREAM: begin
          r_enable_out <= 1'b1;
          r_out_re     <= w_rd_word[2*WIDTH-1:WIDTH];
          r_out_im     <= w_rd_word[WIDTH-1:0];
          r_out_index  <= r_rd_cnt;
          r_rd_cnt     <= r_rd_cnt + 1'b1;
          if (r_rd_cnt == LAST) begin
            r_out_last <= 1'b1;
            r_rd_cnt   <= '0;
            if (w_frame_done) begin
              // back-to-back frame: swap banks without a bubble
              r_rd_bank <= r_wr_bank;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.enable_out = r_enable_out;
  assign bus.out_re     = r_out_re;
  assign bus.out_im     = r_out_im;
  assign bus.out_index  = r_out_index;
  assign bus.out_last   = r_out_last;

endmodule

// File: tb/tb_sdf_bitrev_reorder.sv
module tb_sdf_bitrev_reorder;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   last_cap = 0;
  int   n_total = 0;
  int   n_pass = 0;

  sdf_bitrev_reorder_if #(.WIDTH(8), .LOG2N(4)) bus ();

  sdf_bitrev_reorder #(.WIDTH(8), .N(16), .LOG2N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    string      name;
    logic [7:0] off;
    int         gap_a;
    int         gap_b;
    int         gap_len;
  } vec_t;

  vec_t vecs [4];

  function automatic logic [3:0] brev4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] obs();
    return {10'b0, bus.enable_out, bus.out_last, bus.out_index, bus.out_re, bus.out_im};
  endfunction

  // Drive one frame in bit-reversed order; gaps inserted after samples ga/gb.
  task automatic send_frame(input logic [7:0] off, input int ga, input int gb, input int glen);
    for (int k = 0; k < 16; k++) begin
      logic [3:0] b;
      b = brev4(4'(k));
      bus.enable_in = 1'b1;
      bus.in_re     = 8'(b) + off;
      bus.in_im     = 8'h00 - 8'(b);
      @(posedge clk); #1;
      if (k == 15) last_cap = cyc;
      if (k == ga || k == gb) begin
        bus.enable_in = 1'b0;
        repeat (glen) begin @(posedge clk); #1; end
      end
    end
    bus.enable_in = 1'b0;
  endtask

  // Expect 16 natural-order bins, first one exactly one cycle after the last capture.
  task automatic expect_frame(input logic [7:0] off, input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.enable_out && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!bus.enable_out) begin
      chk({tag, " timeout"}, 32'(t), 32'd0);
      return;
    end
    chk({tag, " latency"}, 32'(cyc - last_cap), 32'd1);
    for (int j = 0; j < 16; j++) begin
      logic [31:0] e;
      e = {10'b0, 1'b1, (j == 15), 4'(j), 8'(j) + off, 8'h00 - 8'(j)};
      chk($sformatf("%s bin%0d", tag, j), obs(), e);
      if (j < 15) @(negedge clk);
    end
  endtask

  initial begin
    int seen;
    int t;
    vecs[0] = '{"single",  8'h00, -1, -1, 0};
    vecs[1] = '{"gapped",  8'h00,  4, 11, 3};
    vecs[2] = '{"gap_edge", 8'h40, 0, 14, 5};
    vecs[3] = '{"wrap",    8'hF0,  7, -1, 1};

    rst_n = 1'b0;
    bus.enable_in = 1'b0;
    bus.in_re = '0;
    bus.in_im = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", obs(), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (obs() != 32'd0) seen++;
    end
    chk("idle outputs", 32'(seen), 32'd0);

    for (int i = 0; i < 4; i++) begin
      fork
        send_frame(vecs[i].off, vecs[i].gap_a, vecs[i].gap_b, vecs[i].gap_len);
        expect_frame(vecs[i].off, vecs[i].name);
      join
      @(negedge clk);
      chk({vecs[i].name, " hold"}, {10'b0, bus.enable_out, bus.out_last, bus.out_index, bus.out_re},
          {18'b0, 4'd15, 8'd15 + vecs[i].off});
    end

    // back-to-back frames: 32 contiguous outputs, no bubble
    fork
      begin
        send_frame(8'h00, -1, -1, 0);
        send_frame(8'h10, -1, -1, 0);
      end
      begin
        expect_frame(8'h00, "b2b_f0");
        expect_frame(8'h10, "b2b_f1");
      end
    join
    @(negedge clk);
    chk("b2b end", 32'(bus.enable_out), 32'd0);

    // reset mid-stream at bin 6
    send_frame(8'h30, -1, -1, 0);
    t = 0;
    @(negedge clk);
    while (!(bus.enable_out && bus.out_index == 4'd6) && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("rst_stream reached bin6", 32'(bus.out_re), 32'h36);
    rst_n = 1'b0;
    #1;
    chk("rst_stream async clear", obs(), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fork
      send_frame(8'h20, -1, -1, 0);
      expect_frame(8'h20, "rst_stream");
    join

    // reset mid-input after 9 samples
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      bus.enable_in = 1'b1;
      bus.in_re     = 8'(brev4(4'(k))) + 8'h50;
      bus.in_im     = 8'h00 - 8'(brev4(4'(k)));
      @(posedge clk); #1;
    end
    bus.enable_in = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fork
      send_frame(8'h60, 2, -1, 2);
      expect_frame(8'h60, "rst_input");
    join
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.enable_out) seen++;
    end
    chk("rst_input extra outputs", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
